// File: rtl/rrv64_l2_line_rsp_serializer.sv
// L2 read-response serializer: one cache line in, BURST_N R-channel beats out.
// Critical-beat-first wrap ordering, back-to-back lines without a bubble.
module rrv64_l2_line_rsp_serializer #(
   parameter int DATA_W     = 128,
   parameter int LINE_W     = 512,
   parameter int ID_W       = 3,
   parameter int BURST_N    = LINE_W / DATA_W,
   parameter int BEAT_IDX_W = (BURST_N > 1) ? $clog2(BURST_N) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  line_vld_i,
   output logic                  line_rdy_o,
   input  logic [ID_W-1:0]       line_id_i,
   input  logic [LINE_W-1:0]     line_data_i,
   input  logic                  line_err_i,
   input  logic [BEAT_IDX_W-1:0] line_start_beat_i,
   output logic                  r_vld_o,
   input  logic                  r_rdy_i,
   output logic [ID_W-1:0]       r_id_o,
   output logic [DATA_W-1:0]     r_data_o,
   output logic [1:0]            r_resp_o,
   output logic                  r_last_o,
   output logic                  busy_o
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [BEAT_IDX_W-1:0] LAST_CNT = BEAT_IDX_W'(BURST_N - 1);

   state_t                  state_q, state_d;
   logic [LINE_W-1:0]       buf_q;
   logic [ID_W-1:0]         id_q;
   logic                    err_q;
   logic [BEAT_IDX_W-1:0]   start_q;
   logic [BEAT_IDX_W-1:0]   cnt_q;
   logic [BEAT_IDX_W-1:0]   beat_idx;
   logic                    hs;
   logic                    last_hs;
   logic                    accept;

   assign r_vld_o    = (state_q == SEND);
   assign r_last_o   = r_vld_o && (cnt_q == LAST_CNT);
   assign hs         = r_vld_o && r_rdy_i;
   assign last_hs    = hs && r_last_o;
   assign line_rdy_o = (state_q == IDLE) || last_hs;
   assign accept     = line_vld_i && line_rdy_o;
   assign busy_o     = (state_q == SEND);

   // Wrap comes from natural overflow of the index width.
   assign beat_idx = (BURST_N == 1) ? '0 : start_q + cnt_q;
   assign r_data_o = buf_q[beat_idx*DATA_W +: DATA_W];
   assign r_id_o   = id_q;
   assign r_resp_o = err_q ? 2'b10 : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = SEND;
         SEND:    if (last_hs && !accept) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // cnt_q is left at the last beat when going idle so R outputs hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q   <= '0;
         id_q    <= '0;
         err_q   <= 1'b0;
         start_q <= '0;
         cnt_q   <= '0;
      end else if (accept) begin
         buf_q   <= line_data_i;
         id_q    <= line_id_i;
         err_q   <= line_err_i;
         start_q <= line_start_beat_i;
         cnt_q   <= '0;
      end else if (hs && !r_last_o) begin
         cnt_q   <= cnt_q + 1'b1;
      end
   end

`ifndef SYNTHESIS
   a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (r_vld_o && !r_rdy_i) |=> (r_vld_o && $stable(r_data_o) &&
         $stable(r_id_o) && $stable(r_resp_o) && $stable(r_last_o)));
   a_last_on_final : assert property (@(posedge clk) disable iff (!rst_n)
      (hs && !r_last_o) |=> (r_vld_o && cnt_q != '0));
`endif

endmodule
